// File: rtl/knn_point_streamer.sv
// Streams training or test points from a point memory to the KNN controller.
// Training points go out as one gapless burst; test points go one at a time, each waiting for its result.
module knn_point_streamer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned TEST_BASE = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start_train,
    input  logic              i_start_test,
    input  logic [7:0]        i_train_count,
    input  logic [7:0]        i_test_count,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_valid,
    output logic              o_data_type,
    output logic [DATA_W-1:0] o_data,
    output logic              o_train_points_update,
    input  logic              i_busy,
    input  logic              i_result_valid,
    output logic              o_ready,
    output logic              o_done,
    output logic [7:0]        o_test_idx,
    output logic [2:0]        o_current_state
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        TRAIN_WAIT   = 3'd1,
        TRAIN_STREAM = 3'd2,
        TEST_WAIT    = 3'd3,
        TEST_SEND    = 3'd4,
        TEST_RESULT  = 3'd5,
        DONE         = 3'd6
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   train_cnt, train_cnt_n;
    logic [CNT_W-1:0]   test_cnt, test_cnt_n;
    logic [CNT_W-1:0]   issued, issued_n;
    logic [CNT_W-1:0]   test_idx_n;
    logic               rd_en_n;
    logic [ADDR_W-1:0]  rd_addr_n;
    logic               upd_n;
    // pend marks the cycle in which memory data for the previous read is on i_rd_data
    logic               pend;
    logic               pend_type;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n     = state;
        train_cnt_n = train_cnt;
        test_cnt_n  = test_cnt;
        issued_n    = issued;
        test_idx_n  = o_test_idx;
        rd_en_n     = 1'b0;
        rd_addr_n   = o_rd_addr;
        upd_n       = 1'b0;
        case (state)
            IDLE: begin
                if (i_start_train) begin
                    state_n     = TRAIN_WAIT;
                    train_cnt_n = i_train_count;
                end else if (i_start_test) begin
                    state_n    = TEST_WAIT;
                    test_cnt_n = i_test_count;
                    test_idx_n = '0;
                end
            end
            TRAIN_WAIT: begin
                if (train_cnt == '0) begin
                    state_n = DONE;
                end else if (!i_busy) begin
                    state_n   = TRAIN_STREAM;
                    upd_n     = 1'b1;
                    rd_en_n   = 1'b1;
                    rd_addr_n = '0;
                    issued_n  = CNT_W'(1);
                end
            end
            TRAIN_STREAM: begin
                // Issue reads back to back; leave once the final beat is on the output.
                if (issued < train_cnt) begin
                    rd_en_n   = 1'b1;
                    rd_addr_n = o_rd_addr + ADDR_W'(1);
                    issued_n  = issued + CNT_W'(1);
                end else if (o_valid && !pend && !o_rd_en) begin
                    state_n = DONE;
                end
            end
            TEST_WAIT: begin
                if (test_cnt == '0) begin
                    state_n = DONE;
                end else if (!i_busy) begin
                    state_n   = TEST_SEND;
                    rd_en_n   = 1'b1;
                    rd_addr_n = ADDR_W'(TEST_BASE) + ADDR_W'(o_test_idx);
                end
            end
            TEST_SEND: begin
                if (o_valid) state_n = TEST_RESULT;
            end
            TEST_RESULT: begin
                if (i_result_valid) begin
                    test_idx_n = o_test_idx + CNT_W'(1);
                    state_n    = (test_idx_n == test_cnt) ? DONE : TEST_WAIT;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            train_cnt             <= '0;
            test_cnt              <= '0;
            issued                <= '0;
            o_test_idx            <= '0;
            o_rd_en               <= 1'b0;
            o_rd_addr             <= '0;
            o_train_points_update <= 1'b0;
            pend                  <= 1'b0;
            pend_type             <= 1'b0;
            o_valid               <= 1'b0;
            o_data_type           <= 1'b0;
            o_data                <= '0;
            o_done                <= 1'b0;
            o_ready               <= 1'b1;
        end else begin
            train_cnt             <= train_cnt_n;
            test_cnt              <= test_cnt_n;
            issued                <= issued_n;
            o_test_idx            <= test_idx_n;
            o_rd_en               <= rd_en_n;
            o_rd_addr             <= rd_addr_n;
            o_train_points_update <= upd_n;
            pend                  <= o_rd_en;
            pend_type             <= (state == TEST_SEND);
            o_valid               <= pend;
            o_data_type           <= pend & pend_type;
            if (pend) o_data      <= i_rd_data;
            o_done                <= (state_n == DONE);
            o_ready               <= (state_n == IDLE);
        end
    end

    assign o_current_state = 3'(state);

endmodule

// File: tb/tb_knn_point_streamer.sv
// Self-checking bench for knn_point_streamer: directed table, random commands and a mid-stream reset,
// all judged against a transaction-level model of reads, beats, results and done timing.
module tb_knn_point_streamer;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned TEST_BASE = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start_train, i_start_test;
    logic [7:0]        i_train_count, i_test_count;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [DATA_W-1:0] i_rd_data;
    logic              o_valid, o_data_type;
    logic [DATA_W-1:0] o_data;
    logic              o_train_points_update;
    logic              i_busy, i_result_valid;
    logic              o_ready, o_done;
    logic [7:0]        o_test_idx;
    logic [2:0]        o_current_state;

    knn_point_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TEST_BASE(TEST_BASE)) dut (
        .clk(clk), .rst(rst),
        .i_start_train(i_start_train), .i_start_test(i_start_test),
        .i_train_count(i_train_count), .i_test_count(i_test_count),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_valid(o_valid), .o_data_type(o_data_type), .o_data(o_data),
        .o_train_points_update(o_train_points_update),
        .i_busy(i_busy), .i_result_valid(i_result_valid),
        .o_ready(o_ready), .o_done(o_done), .o_test_idx(o_test_idx),
        .o_current_state(o_current_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [DATA_W-1:0] mem [256];

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous point memory: data appears the cycle after the read strobe, junk otherwise.
    always @(posedge clk) i_rd_data <= o_rd_en ? mem[o_rd_addr] : DATA_W'($urandom());

    int                rd_cyc_q[$];
    int                rd_addr_q[$];
    int                beat_cyc_q[$];
    logic [DATA_W-1:0] beat_data_q[$];
    bit                beat_type_q[$];
    int                beat_idx_q[$];
    int                upd_cyc_q[$];
    int                done_cyc_q[$];
    int                res_q[$];
    int                bad_cnt;

    always @(negedge clk) begin
        if (rst) begin
            if (o_rd_en) begin rd_cyc_q.push_back(cyc); rd_addr_q.push_back(int'(o_rd_addr)); end
            if (o_valid) begin
                beat_cyc_q.push_back(cyc); beat_data_q.push_back(o_data);
                beat_type_q.push_back(o_data_type); beat_idx_q.push_back(int'(o_test_idx));
            end
            if (o_train_points_update) upd_cyc_q.push_back(cyc);
            if (o_done) done_cyc_q.push_back(cyc);
            if (o_rd_en && (o_current_state inside {3'd0, 3'd5, 3'd6})) bad_cnt++;
            if (o_valid && !(o_current_state inside {3'd2, 3'd4})) bad_cnt++;
            if (o_ready != (o_current_state == 3'd0)) bad_cnt++;
            if (o_done && o_current_state != 3'd6) bad_cnt++;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        rd_cyc_q.delete(); rd_addr_q.delete(); beat_cyc_q.delete(); beat_data_q.delete();
        beat_type_q.delete(); beat_idx_q.delete(); upd_cyc_q.delete(); done_cyc_q.delete();
        res_q.delete(); bad_cnt = 0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = DATA_W'($urandom());
    endtask

    // Issue one command and play the controller (busy, result responses) until done or timeout.
    task automatic run_cmd(input bit tr, input bit te, input int tc, input int sc, input int busy_n,
                           input int lat, input bit noise, output int p, output int busy_low);
        int pending = -1;
        int seen = 0;
        int done_at = -1;
        clear_logs();
        p = cyc;
        busy_low = p + busy_n;
        i_train_count = 8'(tc); i_test_count = 8'(sc);
        i_start_train = tr; i_start_test = te; i_busy = (busy_n > 0); i_result_valid = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            i_start_train = 1'b0; i_start_test = 1'b0; i_result_valid = 1'b0;
            i_busy = (cyc < busy_low);
            if (noise && cyc == p + 4) begin
                i_start_train = 1'b1; i_start_test = 1'b1; i_result_valid = 1'b1;
            end
            if (beat_type_q.size() > seen) begin
                seen = beat_type_q.size();
                if (beat_type_q[seen-1]) pending = beat_cyc_q[seen-1] + lat;
            end
            if (cyc == pending) begin i_result_valid = 1'b1; res_q.push_back(cyc); end
            if (done_at < 0 && done_cyc_q.size() > 0) done_at = done_cyc_q[0];
            if (done_at >= 0 && cyc > done_at + 4) break;
        end
        i_result_valid = 1'b0;
        check("done_timeout", longint'(done_at >= 0), 1);
    endtask

    // Expected behaviour from the command rules: train wins ties, zero count skips straight to done.
    task automatic verify(input string tag, input bit tr, input bit te, input int tc, input int sc,
                          input int p, input int busy_low);
        bit is_train = tr;
        bit is_test  = te && !tr;
        int n = is_train ? tc : (is_test ? sc : 0);
        int first_rd = (p + 2 > busy_low + 1) ? p + 2 : busy_low + 1;
        int errs;
        check({tag, "_reads"}, rd_addr_q.size(), n);
        check({tag, "_beats"}, beat_cyc_q.size(), n);
        check({tag, "_upd"}, upd_cyc_q.size(), (is_train && tc > 0) ? 1 : 0);
        check({tag, "_dones"}, done_cyc_q.size(), 1);
        check({tag, "_protocol"}, bad_cnt, 0);
        if (n == 0) begin
            if (done_cyc_q.size() > 0) check({tag, "_zero_done_cyc"}, done_cyc_q[0], p + 2);
            return;
        end
        if (rd_cyc_q.size() > 0) check({tag, "_first_rd_cyc"}, rd_cyc_q[0], first_rd);
        if (is_train && upd_cyc_q.size() > 0) check({tag, "_upd_cyc"}, upd_cyc_q[0], first_rd);
        errs = 0;
        for (int i = 0; i < rd_addr_q.size(); i++) begin
            int ea = is_train ? i : int'(ADDR_W'(TEST_BASE + i));
            if (rd_addr_q[i] != ea) errs++;
            if (is_train && rd_cyc_q[i] != rd_cyc_q[0] + i) errs++;
        end
        check({tag, "_addr_seq"}, errs, 0);
        errs = 0;
        for (int i = 0; i < beat_cyc_q.size(); i++) begin
            int ea = is_train ? i : int'(ADDR_W'(TEST_BASE + i));
            if (beat_data_q[i] !== mem[ea]) errs++;
            if (beat_type_q[i] != is_test) errs++;
            if (is_train && beat_cyc_q[i] != beat_cyc_q[0] + i) errs++;
            if (is_test && beat_idx_q[i] != i) errs++;
        end
        check({tag, "_beat_seq"}, errs, 0);
        if (done_cyc_q.size() > 0 && beat_cyc_q.size() > 0) begin
            if (is_train) check({tag, "_done_cyc"}, done_cyc_q[0], beat_cyc_q[beat_cyc_q.size()-1] + 1);
            else if (res_q.size() > 0) check({tag, "_done_cyc"}, done_cyc_q[0], res_q[res_q.size()-1] + 1);
        end
        if (is_test) check({tag, "_results"}, res_q.size(), n);
    endtask

    typedef struct {
        bit tr; bit te; int tc; int sc; int busy; int lat;
        int exp_reads; int exp_beats; int exp_upd; int exp_done;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int p, bl;
        vecs[0] = '{1, 0, 128, 0,   0,  1, 128, 128, 1, 1};
        vecs[1] = '{0, 1, 0,   3,   0,  10, 3,  3,   0, 1};
        vecs[2] = '{0, 1, 0,   1,   20, 2,  1,  1,   0, 1};
        vecs[3] = '{1, 1, 4,   5,   0,  3,  4,  4,   1, 1};
        vecs[4] = '{1, 0, 0,   0,   0,  1,  0,  0,   0, 1};
        vecs[5] = '{0, 1, 0,   0,   0,  1,  0,  0,   0, 1};
        vecs[6] = '{1, 0, 1,   0,   3,  1,  1,  1,   1, 1};
        vecs[7] = '{0, 1, 0,   128, 0,  1,  128, 128, 0, 1};

        rst = 1'b0;
        i_start_train = 1'b0; i_start_test = 1'b0; i_busy = 1'b0; i_result_valid = 1'b0;
        i_train_count = '0; i_test_count = '0;
        fill_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", o_current_state, 0);
        check("rst_ready", o_ready, 1);
        check("rst_outs", {o_rd_en, o_valid, o_data_type, o_train_points_update, o_done}, 0);
        check("rst_vals", longint'(o_data) + o_rd_addr + o_test_idx, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            fill_mem();
            run_cmd(vecs[v].tr, vecs[v].te, vecs[v].tc, vecs[v].sc, vecs[v].busy, vecs[v].lat, 1'b0, p, bl);
            check($sformatf("vec%0d_reads", v), rd_addr_q.size(), vecs[v].exp_reads);
            check($sformatf("vec%0d_beats", v), beat_cyc_q.size(), vecs[v].exp_beats);
            check($sformatf("vec%0d_upd", v), upd_cyc_q.size(), vecs[v].exp_upd);
            check($sformatf("vec%0d_done", v), done_cyc_q.size(), vecs[v].exp_done);
            verify($sformatf("vec%0d", v), vecs[v].tr, vecs[v].te, vecs[v].tc, vecs[v].sc, p, bl);
        end

        for (int r = 0; r < 12; r++) begin
            bit tr = 1'($urandom_range(0, 1));
            bit te = 1'($urandom_range(0, 1));
            int tc = $urandom_range(0, 12);
            int sc = $urandom_range(0, 6);
            int bz = $urandom_range(0, 5);
            int lt = $urandom_range(1, 6);
            bit nz = tr && tc > 0 && ($urandom_range(0, 1) == 1);
            if (!tr && !te) te = 1'b1;
            fill_mem();
            run_cmd(tr, te, tc, sc, bz, lt, nz, p, bl);
            verify($sformatf("rnd%0d", r), tr, te, tc, sc, p, bl);
        end

        // Reset in the middle of a 128-point training burst.
        fill_mem();
        clear_logs();
        i_train_count = 8'd128; i_start_train = 1'b1;
        @(posedge clk); #1;
        i_start_train = 1'b0;
        for (int k = 0; k < 400 && beat_cyc_q.size() < 50; k++) begin
            @(posedge clk); #1;
        end
        check("rst_mid_reached50", beat_cyc_q.size(), 50);
        rst = 1'b0;
        #1;
        check("rst_mid_state", o_current_state, 0);
        check("rst_mid_ready", o_ready, 1);
        check("rst_mid_outs", {o_rd_en, o_valid, o_data_type, o_train_points_update, o_done}, 0);
        check("rst_mid_vals", longint'(o_data) + o_rd_addr + o_test_idx, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        run_cmd(1'b1, 1'b0, 2, 0, 0, 1, 1'b0, p, bl);
        verify("post_rst", 1'b1, 1'b0, 2, 0, p, bl);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/knn_point_streamer.md
KNN_POINT_STREAMER -- requirements
Module: knn_point_streamer

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, point word width; ADDR_W, default 8, point memory address width; TEST_BASE, default 128, first test-point address.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous reset, active-low.
- i_start_train, in, 1, pulse: stream training points.
- i_start_test, in, 1, pulse: stream test points.
- i_train_count, in, 8, training point count, 0..128.
- i_test_count, in, 8, test point count, 0..128.
- o_rd_en, out, 1, point memory read strobe.
- o_rd_addr, out, ADDR_W, point memory read address.
- i_rd_data, in, DATA_W, memory data, valid exactly 1 cycle after o_rd_en.
- o_valid, out, 1, point beat to controller i_valid.
- o_data_type, out, 1, to controller i_data_type: 1 = test point, 0 = training point.
- o_data, out, DATA_W, point word.
- o_train_points_update, out, 1, to controller i_train_points_update.
- i_busy, in, 1, controller o_busy.
- i_result_valid, in, 1, controller o_valid: classification done.
- o_ready, out, 1, high in IDLE only.
- o_done, out, 1, 1-cycle pulse at end of each command.
- o_test_idx, out, 8, index of the test point in flight.
- o_current_state, out, 3, state encoding.

Function
REQ-003 States and o_current_state encodings SHALL be: IDLE=0, TRAIN_WAIT=1, TRAIN_STREAM=2, TEST_WAIT=3, TEST_SEND=4, TEST_RESULT=5, DONE=6.
REQ-004 Transitions from IDLE SHALL be:
- i_start_train -> TRAIN_WAIT.
- else i_start_test -> TEST_WAIT.
- Both asserted together: train wins and the test pulse is dropped.
- Start pulses outside IDLE SHALL be ignored.
REQ-005 Counts SHALL be latched on the accepted start pulse; a latched count of 0 SHALL go directly to DONE with no reads and no beats.
REQ-006 TRAIN_WAIT SHALL hold until i_busy=0, then assert o_train_points_update for exactly 1 cycle and enter TRAIN_STREAM on the next cycle.
REQ-007 TRAIN_STREAM SHALL read consecutively:
- o_rd_en high for N consecutive cycles with o_rd_addr = 0..N-1, N = latched train count.
- Each read SHALL produce a beat 1 cycle later: o_valid=1, o_data_type=0, o_data=i_rd_data.
- The result is N back-to-back beats with no gaps, not throttled by i_busy.
REQ-008 TRAIN_STREAM SHALL enter DONE in the cycle after the last beat.
REQ-009 TEST_WAIT SHALL hold until i_busy=0, then issue one read at TEST_BASE+o_test_idx and enter TEST_SEND.
REQ-010 TEST_SEND SHALL emit exactly one beat (o_valid=1, o_data_type=1, o_data=i_rd_data), then enter TEST_RESULT.
REQ-011 TEST_RESULT SHALL wait for i_result_valid=1, then:
- increment o_test_idx;
- enter DONE if o_test_idx reached the latched test count, else TEST_WAIT.
REQ-012 i_result_valid SHALL be ignored in all states other than TEST_RESULT.
REQ-013 DONE SHALL pulse o_done for 1 cycle and return to IDLE; o_test_idx SHALL clear on entry to TEST_WAIT from IDLE.
REQ-014 o_valid SHALL be low except in the beat cycles defined in REQ-007 and REQ-010; o_rd_en SHALL never be high in IDLE, DONE or TEST_RESULT.
REQ-015 Address arithmetic SHALL be ADDR_W bits with wrap-around modulo 2^ADDR_W; no overflow flag.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 On rst=0, asynchronously:
- state=IDLE;
- o_rd_en, o_valid, o_data_type, o_train_points_update, o_done = 0;
- o_data, o_rd_addr, o_test_idx = 0;
- o_ready = 1;
- latched counts = 0.
REQ-018 Reset asserted mid-stream SHALL abort the command immediately with no further beats; after reset release, the first rising clk edge SHALL accept a new start.

Verification
REQ-019 Train load: i_train_count=128, i_start_train, i_busy=0 ->
- 1-cycle o_train_points_update;
- 128 consecutive reads, addr 0..127;
- 128 gapless beats, o_data_type=0, o_data matching memory;
- o_done 1 cycle after the last beat.
REQ-020 Test sequence: i_test_count=3, result returned 10 cycles after each beat ->
- 3 beats, o_data_type=1, addresses 128,129,130;
- o_test_idx 0,1,2 during the beats;
- o_done after the 3rd result.
REQ-021 Busy gating: i_busy=1 held 20 cycles at i_start_test -> no o_rd_en and no o_valid until i_busy falls; first read in the cycle after i_busy=0.
REQ-022 Simultaneous start_train and start_test with train count 4 -> only 4 training beats, no test beat, 1 o_done.
REQ-023 Zero count: i_train_count=0 -> no o_rd_en, no o_valid, no o_train_points_update; o_done 2 cycles after start.
REQ-024 Reset after the 50th training beat -> all outputs at reset values within the same cycle, no further beats, o_ready=1.
